// File: rtl/flip_pkg.sv
// rtl/flip_pkg.sv - shared widths and state encoding for the bottle-flip game
package flip_pkg;
  localparam int POWER_W      = 6;
  localparam int ANGLE_W      = 4;
  localparam int SCORE_DIGITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHARGE = 3'd1,
    ST_FLIGHT = 3'd2,
    ST_LAND   = 3'd3,
    ST_RESULT = 3'd4
  } state_e;
endpackage

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - multi-digit BCD incrementer, wraps from all-nines to zero
module bcd_counter4
  import flip_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      clr_ni,
  input  logic                      inc_i,
  output logic [4*SCORE_DIGITS-1:0] bcd_o
);

  logic [4*SCORE_DIGITS-1:0] bcd_q, bcd_d;
  logic                      carry;

  // Ripple the increment upward; a digit at 9 rolls to 0 and passes the carry on.
  always_comb begin
    bcd_d = bcd_q;
    carry = inc_i;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_d[4*i +: 4] = 4'd0;
        end else begin
          bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) bcd_q <= '0;
    else         bcd_q <= bcd_d;
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/flip_game_ctrl.sv
// rtl/flip_game_ctrl.sv - throw sequencer: charge, flight, land, result; owns all game state
module flip_game_ctrl
  import flip_pkg::*;
#(
  parameter int MAX_POWER   = 63,
  parameter int WIN_LO      = 28,
  parameter int WIN_HI      = 36,
  parameter int SHOW_FRAMES = 60
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      frame_tick,
  input  logic                      btn,
  output logic [2:0]                state,
  output logic [POWER_W-1:0]        power,
  output logic [ANGLE_W-1:0]        angle,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic                      hit,
  output logic                      miss
);

  localparam int FRAME_W = $clog2(SHOW_FRAMES + 1);
  localparam logic [POWER_W-1:0] MAX_P    = POWER_W'(MAX_POWER);
  localparam logic [POWER_W-1:0] WIN_LO_P = POWER_W'(WIN_LO);
  localparam logic [POWER_W-1:0] WIN_HI_P = POWER_W'(WIN_HI);
  localparam logic [FRAME_W-1:0] LAST_F   = FRAME_W'(SHOW_FRAMES - 1);

  state_e               state_q, state_d;
  logic [POWER_W-1:0]   power_q, power_d;
  logic [POWER_W-1:0]   flight_q, flight_d;
  logic [ANGLE_W-1:0]   angle_q, angle_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 hit_q, hit_d, miss_q, miss_d;
  logic                 win, score_inc;

  assign win = (power_q >= WIN_LO_P) && (power_q <= WIN_HI_P);

  always_comb begin
    state_d   = state_q;
    power_d   = power_q;
    flight_d  = flight_q;
    angle_d   = angle_q;
    frame_d   = frame_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    score_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn) begin
          state_d = ST_CHARGE;
          power_d = '0;
        end
      end
      ST_CHARGE: begin
        // Release takes priority over a coincident frame tick.
        if (!btn) begin
          if (power_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_FLIGHT;
            flight_d = power_q;
          end
        end else if (frame_tick && (power_q < MAX_P)) begin
          power_d = power_q + 1'b1;
        end
      end
      ST_FLIGHT: begin
        if (frame_tick) begin
          angle_d  = angle_q + 1'b1;
          flight_d = flight_q - 1'b1;
          if (flight_q == POWER_W'(1)) state_d = ST_LAND;
        end
      end
      ST_LAND: begin
        state_d = ST_RESULT;
        frame_d = '0;
        if (win) begin
          hit_d     = 1'b1;
          score_inc = 1'b1;
          angle_d   = '0;
        end else begin
          miss_d = 1'b1;
        end
      end
      ST_RESULT: begin
        if (frame_tick) begin
          if (frame_q == LAST_F) begin
            state_d = ST_IDLE;
            power_d = '0;
            angle_d = '0;
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      power_q  <= '0;
      flight_q <= '0;
      angle_q  <= '0;
      frame_q  <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      power_q  <= power_d;
      flight_q <= flight_d;
      angle_q  <= angle_d;
      frame_q  <= frame_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  bcd_counter4 u_score (
    .clk_i  (clk),
    .clr_ni (clr),
    .inc_i  (score_inc),
    .bcd_o  (score_bcd)
  );

  assign state = state_q;
  assign power = power_q;
  assign angle = angle_q;
  assign hit   = hit_q;
  assign miss  = miss_q;

endmodule

// File: tb/tb_flip_game_ctrl.sv
// tb/tb_flip_game_ctrl.sv - self-checking bench: vector table, corner sequences, random throws
module tb_flip_game_ctrl;
  import flip_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        frame_tick = 1'b0;
  logic        btn = 1'b0;
  logic        bcd_inc = 1'b0;
  logic [2:0]  state;
  logic [5:0]  power;
  logic [3:0]  angle;
  logic [15:0] score_bcd;
  logic [15:0] bcd_q;
  logic        hit, miss;

  int n_pass  = 0;
  int n_total = 0;
  int exp_score = 0;

  typedef struct {
    int hold;
    bit coinc;
    int exp_power;
    bit exp_hit;
    int exp_land_angle;
  } vec_t;

  flip_game_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .frame_tick (frame_tick),
    .btn        (btn),
    .state      (state),
    .power      (power),
    .angle      (angle),
    .score_bcd  (score_bcd),
    .hit        (hit),
    .miss       (miss)
  );

  bcd_counter4 u_bcd (
    .clk_i  (clk),
    .clr_ni (clr),
    .inc_i  (bcd_inc),
    .bcd_o  (bcd_q)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int x;
    x = v % 10000;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic do_throw(input int hold, input bit coinc, input bit keep,
                          input int ep, input bit ehit, input int eland);
    int n;
    btn = 1'b1;
    step();
    chk("charge_entry", state, 1);
    chk("charge_power0", power, 0);
    for (int i = 0; i < hold; i++) pulse_tick();
    btn = 1'b0;
    frame_tick = coinc;
    step();
    frame_tick = 1'b0;
    chk("release_state", state, 2);
    chk("release_power", power, ep);
    if (keep) btn = 1'b1;
    n = 0;
    while (n < 100 && state == 3'd2) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n++;
      if (state == 3'd2) step();
    end
    chk("flight_len", n, ep);
    chk("land_state", state, 3);
    chk("land_angle", angle, eland);
    step();
    chk("result_state", state, 4);
    chk("hit_pulse", hit, int'(ehit));
    chk("miss_pulse", miss, int'(!ehit));
    if (ehit) exp_score++;
    chk("score", score_bcd, to_bcd(exp_score));
    chk("result_angle", angle, ehit ? 0 : eland);
    step();
    chk("pulse_width", int'(hit | miss), 0);
    for (int i = 0; i < 59; i++) pulse_tick();
    chk("result_hold", state, 4);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("idle_state", state, 0);
    chk("idle_power", power, 0);
    chk("idle_angle", angle, 0);
    if (keep) begin
      step();
      chk("recharge_after_idle", state, 1);
      btn = 1'b0;
      step();
      chk("recharge_abort", state, 0);
    end
  endtask

  initial begin
    vec_t vecs[7];
    int hold, p;
    bit coinc, h;

    // 7 entries, 3 hits: score ends at 0003 for the reset test.
    vecs[0] = '{30, 1'b0, 30, 1'b1, 14};
    vecs[1] = '{80, 1'b0, 63, 1'b0, 15};
    vecs[2] = '{28, 1'b0, 28, 1'b1, 12};
    vecs[3] = '{37, 1'b0, 37, 1'b0, 5};
    vecs[4] = '{36, 1'b0, 36, 1'b1, 4};
    vecs[5] = '{27, 1'b1, 27, 1'b0, 11};
    vecs[6] = '{27, 1'b0, 27, 1'b0, 11};

    #12;
    chk("rst_state", state, 0);
    chk("rst_power", power, 0);
    chk("rst_angle", angle, 0);
    chk("rst_score", score_bcd, 0);
    chk("rst_hit", hit, 0);
    chk("rst_miss", miss, 0);
    clr = 1'b1;
    step();

    for (int i = 0; i < 7; i++)
      do_throw(vecs[i].hold, vecs[i].coinc, 1'b0, vecs[i].exp_power,
               vecs[i].exp_hit, vecs[i].exp_land_angle);
    chk("score_before_reset", score_bcd, 16'h0003);

    // Reset mid-flight must clear everything without waiting for a clock edge.
    btn = 1'b1;
    step();
    for (int i = 0; i < 5; i++) pulse_tick();
    btn = 1'b0;
    step();
    pulse_tick();
    pulse_tick();
    chk("midflight_state", state, 2);
    #2 clr = 1'b0;
    #1;
    chk("clr_state", state, 0);
    chk("clr_power", power, 0);
    chk("clr_angle", angle, 0);
    chk("clr_score", score_bcd, 0);
    chk("clr_hitmiss", int'(hit | miss), 0);
    exp_score = 0;
    step();
    clr = 1'b1;
    step();

    // Press and release with no frame tick: abort back to idle.
    btn = 1'b1;
    step();
    chk("tap_charge", state, 1);
    btn = 1'b0;
    step();
    chk("tap_idle", state, 0);
    chk("tap_power", power, 0);
    chk("tap_hitmiss", int'(hit | miss), 0);
    step();
    chk("tap_hitmiss_late", int'(hit | miss), 0);

    // Coincident release at 27, button held through RESULT.
    do_throw(27, 1'b1, 1'b1, 27, 1'b0, 11);

    // Random throws against the rule-level model.
    for (int r = 0; r < 12; r++) begin
      hold  = $urandom_range(1, 70);
      coinc = 1'($urandom_range(0, 1));
      p     = (hold > 63) ? 63 : hold;
      h     = (p >= 28) && (p <= 36);
      do_throw(hold, coinc, 1'b0, p, h, p % 16);
    end

    // BCD carry and wrap on a standalone counter.
    chk("bcd_start", bcd_q, 0);
    bcd_inc = 1'b1;
    repeat (99) step();
    chk("bcd_0099", bcd_q, 16'h0099);
    step();
    chk("bcd_0100", bcd_q, 16'h0100);
    repeat (9899) step();
    chk("bcd_9999", bcd_q, 16'h9999);
    step();
    chk("bcd_wrap", bcd_q, 16'h0000);
    bcd_inc = 1'b0;
    step();
    chk("bcd_hold", bcd_q, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
